// File: rtl/reset_sequencer_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
//   rst_seq_state_e : global sequencing FSM states
//   cnt_width       : bits needed for a down-counter loaded with max_val
//   max2            : larger of two integers
//   idx_width       : bits needed to index n channels (at least 1)
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        STRETCH = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } rst_seq_state_e;

    function automatic int cnt_width(input int max_val);
        return ($clog2(max_val + 1) < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Reset sequencer channel bundle.
//   sw_rst_req_i  : per-channel soft-reset request (requester -> sequencer)
//   rst_n_o       : sequenced active-low resets, bit 0 released first
//   rst_done_o    : global sequence complete
//   sw_rst_busy_o : per-channel soft reset in progress
// master = requester/consumer side, slave = reset_sequencer.
interface reset_sequencer_if #(
    parameter int NUM_RST = 4
) ();
    logic [NUM_RST-1:0] sw_rst_req_i;
    logic [NUM_RST-1:0] rst_n_o;
    logic               rst_done_o;
    logic [NUM_RST-1:0] sw_rst_busy_o;

    modport master (
        output sw_rst_req_i,
        input  rst_n_o,
        input  rst_done_o,
        input  sw_rst_busy_o
    );

    modport slave (
        input  sw_rst_req_i,
        output rst_n_o,
        output rst_done_o,
        output sw_rst_busy_o
    );
endinterface

// File: rtl/rst_seq_chan.sv
// One sequenced reset channel: holds its reset flop, soft-reset busy flop
// and soft-reset down-counter.
//   clk, rst_n_i  : clock and asynchronous active-low reset
//   release_stb   : one-cycle strobe from the global sequencer releasing this channel
//   run_en        : global sequence finished, soft resets allowed
//   sw_req        : soft-reset request, synchronous to clk
//   chan_rst_n    : registered active-low reset output
//   chan_busy     : registered soft-reset busy flag
module rst_seq_chan
    import reset_sequencer_pkg::*;
#(
    parameter int SRST_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n_i,
    input  logic release_stb,
    input  logic run_en,
    input  logic sw_req,
    output logic chan_rst_n,
    output logic chan_busy
);

    localparam int CNT_W = cnt_width(SRST_CYCLES);
    localparam logic [CNT_W-1:0] SRST_LOAD = CNT_W'(SRST_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             rst_n_r;
    logic             busy_r;
    logic [CNT_W-1:0] cnt_r;

    // Channel reset, busy flag and soft-reset counter.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rst_n_r <= 1'b0;
            busy_r  <= 1'b0;
            cnt_r   <= '0;
        end else if (run_en && sw_req) begin
            // A request while busy simply reloads, stretching the low time.
            rst_n_r <= 1'b0;
            busy_r  <= 1'b1;
            cnt_r   <= SRST_LOAD;
        end else if (busy_r) begin
            // Treat 0 like 1 so a corrupted counter can never wrap.
            if (cnt_r <= CNT_ONE) begin
                rst_n_r <= 1'b1;
                busy_r  <= 1'b0;
                cnt_r   <= '0;
            end else begin
                cnt_r <= cnt_r - CNT_ONE;
            end
        end else if (release_stb) begin
            rst_n_r <= 1'b1;
        end else begin
            rst_n_r <= rst_n_r;
        end
    end

    assign chan_rst_n = rst_n_r;
    assign chan_busy  = busy_r;

endmodule

// File: rtl/reset_sequencer.sv
// Multi-domain reset sequencer. Synchronises rst_n_i deassertion, stretches
// the reset, then releases NUM_RST channels in order with a fixed gap. Once
// the sequence completes each channel may be soft-reset independently.
//   clk     : destination clock
//   rst_n_i : asynchronous active-low reset (deassertion synchronised here)
//   bus     : slave side of reset_sequencer_if (requests in, resets/status out)
// All outputs are flop outputs.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES    = 3,
    parameter int NUM_RST        = 4,
    parameter int STRETCH_CYCLES = 16,
    parameter int RELEASE_GAP    = 8,
    parameter int SRST_CYCLES    = 8
) (
    input  logic             clk,
    input  logic             rst_n_i,
    reset_sequencer_if.slave bus
);

    localparam int SEQ_CNT_W = cnt_width(max2(STRETCH_CYCLES, RELEASE_GAP));
    localparam int IDX_W     = idx_width(NUM_RST);

    localparam logic [SEQ_CNT_W-1:0] STRETCH_LOAD = SEQ_CNT_W'(STRETCH_CYCLES);
    localparam logic [SEQ_CNT_W-1:0] GAP_LOAD     = SEQ_CNT_W'(RELEASE_GAP);
    localparam logic [SEQ_CNT_W-1:0] CNT_ONE      = SEQ_CNT_W'(1);
    localparam logic [IDX_W-1:0]     IDX_ONE      = IDX_W'(1);
    localparam logic [IDX_W-1:0]     LAST_IDX     = IDX_W'(NUM_RST - 1);
    localparam logic [NUM_RST-1:0]   CHAN_ONE     = NUM_RST'(1);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_r;

    rst_seq_state_e       state_r;
    rst_seq_state_e       state_s;
    logic [SEQ_CNT_W-1:0] cnt_r;
    logic [SEQ_CNT_W-1:0] cnt_s;
    logic [IDX_W-1:0]     idx_r;
    logic [IDX_W-1:0]     idx_s;
    logic                 done_r;
    logic                 fire_s;
    logic                 sync_setting_s;
    logic [NUM_RST-1:0]   release_s;
    logic                 run_en_s;
    logic [NUM_RST-1:0]   chan_rst_n_s;
    logic [NUM_RST-1:0]   chan_busy_s;

    // Deassertion synchroniser; the last stage is rst_n_sync.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // The stage feeding rst_n_sync: HOLD is left on the very edge that sets
    // rst_n_sync, so the stretch is counted from that edge.
    assign sync_setting_s = sync_r[SYNC_STAGES-2];

    // The active stretch/gap interval ends on this edge.
    assign fire_s = ((state_r == STRETCH) || (state_r == RELEASE)) && (cnt_r == CNT_ONE);

    // FSM state, stretch/gap counter and channel index.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= HOLD;
            cnt_r   <= '0;
            idx_r   <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        idx_s   = idx_r;
        case (state_r)
            HOLD: begin
                if (sync_setting_s) begin
                    state_s = STRETCH;
                    cnt_s   = STRETCH_LOAD;
                end else begin
                    state_s = HOLD;
                end
            end
            STRETCH: begin
                if (fire_s) begin
                    cnt_s = GAP_LOAD;
                    if (NUM_RST == 1) begin
                        state_s = RUN;
                    end else begin
                        state_s = RELEASE;
                        idx_s   = IDX_ONE;
                    end
                end else begin
                    cnt_s = (cnt_r != '0) ? (cnt_r - CNT_ONE) : '0;
                end
            end
            RELEASE: begin
                if (fire_s) begin
                    cnt_s = GAP_LOAD;
                    if (idx_r == LAST_IDX) begin
                        state_s = RUN;
                    end else begin
                        idx_s = idx_r + IDX_ONE;
                    end
                end else begin
                    cnt_s = (cnt_r != '0) ? (cnt_r - CNT_ONE) : '0;
                end
            end
            RUN: begin
                state_s = RUN;
            end
            default: begin
                state_s = HOLD;
                cnt_s   = '0;
                idx_s   = '0;
            end
        endcase
    end

    // Release strobe for the indexed channel and soft-reset enable.
    always_comb begin
        release_s = '0;
        run_en_s  = 1'b0;
        if (fire_s) begin
            release_s = CHAN_ONE << idx_r;
        end else begin
            release_s = '0;
        end
        run_en_s = (state_r == RUN);
    end

    // Done rises one edge after the last channel is released.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            done_r <= 1'b0;
        end else begin
            done_r <= (state_r == RUN);
        end
    end

    for (genvar i = 0; i < NUM_RST; i++) begin : g_chan
        rst_seq_chan #(
            .SRST_CYCLES (SRST_CYCLES)
        ) u_chan (
            .clk         (clk),
            .rst_n_i     (rst_n_i),
            .release_stb (release_s[i]),
            .run_en      (run_en_s),
            .sw_req      (bus.sw_rst_req_i[i]),
            .chan_rst_n  (chan_rst_n_s[i]),
            .chan_busy   (chan_busy_s[i])
        );
    end

    assign bus.rst_n_o       = chan_rst_n_s;
    assign bus.sw_rst_busy_o = chan_busy_s;
    assign bus.rst_done_o    = done_r;

endmodule
